// File: rtl/rat_int_ctrl.sv
// Interrupt controller for the RAT MCU: edge-captures IRQ lines into pending latches
// and hands the lowest-index enabled channel to the control unit, one handler at a time.
module rat_int_ctrl #(
   parameter int          N_CH     = 4,
   parameter logic [9:0]  VEC_BASE = 10'h3F8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [N_CH-1:0] IRQ,
   input  logic            I_SET,
   input  logic            I_CLR,
   input  logic            MASK_WE,
   input  logic [N_CH-1:0] MASK_DIN,
   input  logic            INT_ACK,
   input  logic            RETI,
   output logic            INT_CU,
   output logic [9:0]      INT_VEC,
   output logic [2:0]      INT_ID,
   output logic [N_CH-1:0] PEND,
   output logic            IN_SERVICE
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N_CH-1:0] irq_q, irq_d;
   logic [N_CH-1:0] pend_q, pend_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic            gie_q, gie_d;
   logic [2:0]      int_id_q, int_id_d;
   logic            int_cu_q, int_cu_d;
   logic            in_service_q, in_service_d;

   logic [N_CH-1:0] irq_rise;
   logic [N_CH-1:0] eligible;
   logic [N_CH-1:0] ack_clr;
   logic [N_CH-1:0] pend_clr;
   logic [2:0]      sel_id;

   always_comb begin
      irq_d    = IRQ;
      irq_rise = IRQ & ~irq_q;
      eligible = pend_q & mask_q;

      // Scan from the top down so the lowest-index eligible channel wins.
      sel_id = 3'd0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (eligible[i]) sel_id = 3'(i);
      end

      ack_clr = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int_id_q == 3'(i)) ack_clr[i] = 1'b1;
      end

      state_d  = state_q;
      int_id_d = int_id_q;
      pend_clr = '0;
      mask_d   = MASK_WE ? MASK_DIN : mask_q;

      // CLI beats SEI; the ACK/RETI handshake below overrides both.
      gie_d = gie_q;
      if (I_SET) gie_d = 1'b1;
      if (I_CLR) gie_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (gie_q && (|eligible)) begin
               state_d  = S_REQ;
               int_id_d = sel_id;
            end
         end
         S_REQ: begin
            if (INT_ACK) begin
               state_d  = S_SERVICE;
               pend_clr = ack_clr;
               gie_d    = 1'b0;
            end
         end
         S_SERVICE: begin
            if (RETI) begin
               state_d = S_IDLE;
               gie_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new edge on the channel being acknowledged keeps it pending.
      pend_d       = (pend_q & ~pend_clr) | irq_rise;
      int_cu_d     = (state_d == S_REQ);
      in_service_d = (state_d == S_SERVICE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         irq_q        <= IRQ;
         pend_q       <= '0;
         mask_q       <= '1;
         gie_q        <= 1'b0;
         int_id_q     <= 3'd0;
         int_cu_q     <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq_d;
         pend_q       <= pend_d;
         mask_q       <= mask_d;
         gie_q        <= gie_d;
         int_id_q     <= int_id_d;
         int_cu_q     <= int_cu_d;
         in_service_q <= in_service_d;
      end
   end

   assign INT_CU     = int_cu_q;
   assign IN_SERVICE = in_service_q;
   assign INT_ID     = int_id_q;
   assign INT_VEC    = VEC_BASE + {7'd0, int_id_q};
   assign PEND       = pend_q;

endmodule

// File: doc/rat_int_ctrl.md
RAT_INT_CTRL -- requirements
Module: rat_int_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 4 (legal 1..8), meaning the number of interrupt request channels.
REQ-002 The block SHALL have parameter VEC_BASE, default 10'h3F8, meaning the program address of the channel-0 interrupt vector.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-004 CLK  in  1  system clock; all state changes occur on its rising edge.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 IRQ  in  N_CH  per-channel request lines, synchronous to CLK, rising-edge sensitive.
REQ-007 I_SET  in  1  from the control unit; sets the global interrupt enable (SEI).
REQ-008 I_CLR  in  1  from the control unit; clears the global interrupt enable (CLI).
REQ-009 MASK_WE  in  1  mask register write strobe.
REQ-010 MASK_DIN  in  N_CH  new mask value (1 = channel enabled).
REQ-011 INT_ACK  in  1  control unit has entered its interrupt cycle.
REQ-012 RETI  in  1  control unit is executing return-from-interrupt.
REQ-013 INT_CU  out  1  interrupt request to the control unit.
REQ-014 INT_VEC  out  10  vector address for the PC mux.
REQ-015 INT_ID  out  3  index of the channel being requested or serviced.
REQ-016 PEND  out  N_CH  pending-latch status.
REQ-017 IN_SERVICE  out  1  high while a handler is active.

Function
REQ-018 Each IRQ bit SHALL be registered once (irq_q), and an edge SHALL be IRQ[i] & ~irq_q[i].
REQ-019 A detected edge SHALL set PEND[i] on the same clock edge that samples it, so PEND is visible one cycle after IRQ first reads high.
REQ-020 If set and clear of a PEND bit coincide, set SHALL win.
REQ-021 MASK SHALL load MASK_DIN on any edge with MASK_WE = 1; masking never clears PEND.
REQ-022 Global enable GIE: I_CLR SHALL have priority over I_SET when both are high.
REQ-023 The state machine SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-024 IDLE -> REQ SHALL occur when GIE = 1 and (PEND & MASK) != 0; the lowest-index eligible channel is latched into INT_ID on that edge.
REQ-025 In REQ, INT_CU SHALL be 1 (registered, so it is first high one cycle after the eligible PEND bit is first high), and INT_ID/INT_VEC SHALL be held constant.
REQ-026 A REQ commitment SHALL NOT be withdrawn by a later mask write, I_CLR or higher-priority edge; it is held until INT_ACK.
REQ-027 REQ -> SERVICE SHALL occur on INT_ACK; on the same edge PEND[INT_ID] is cleared (REQ-020 applies) and GIE is cleared.
REQ-028 In SERVICE: INT_CU = 0 and IN_SERVICE = 1; edges are still captured into PEND; no nesting occurs.
REQ-029 SERVICE -> IDLE SHALL occur on RETI, and GIE SHALL be set to 1 on the same edge.
REQ-030 INT_ACK outside REQ and RETI outside SERVICE SHALL be ignored.
REQ-031 INT_VEC SHALL equal VEC_BASE + INT_ID, truncated to 10 bits (wraps past 10'h3FF).
REQ-032 Back-to-back operation: after RETI, an eligible pending channel SHALL reach REQ on the next edge (IDLE for 1 cycle).
REQ-033 Bits of MASK_DIN, PEND and INT_ID above N_CH-1 SHALL be ignored or held at 0.

Reset
REQ-034 On RESET = 1 the block SHALL load: state IDLE, PEND = 0, MASK = all ones, GIE = 0, INT_ID = 0, INT_CU = 0, IN_SERVICE = 0, so INT_VEC = VEC_BASE.
REQ-035 During reset, irq_q SHALL load the current IRQ value, so lines already high at reset release generate no edge.
REQ-036 Reset SHALL override every other input, including mid-REQ and mid-SERVICE, and SHALL abort the active request or handler with no pending retained.

Verification
REQ-037 GIE = 1, IRQ[2] goes 0 -> 1 -> PEND = 4'b0100 the next cycle, INT_CU = 1 and INT_ID = 2 one cycle later, INT_VEC = 10'h3FA.
REQ-038 Edges arrive simultaneously on IRQ[3] and IRQ[1], with INT_ACK then RETI -> channel 1 is serviced first; PEND = 4'b1000 after the ACK; channel 3 reaches REQ one cycle after RETI.
REQ-039 Mask = 4'b1110, edge on IRQ[0] -> PEND[0] = 1 and INT_CU stays 0; writing mask 4'b0001 -> INT_CU = 1 and INT_ID = 0.
REQ-040 GIE = 0, edge on IRQ[1], then I_SET and I_CLR both high -> GIE stays 0 and INT_CU stays 0; I_SET alone -> REQ entered.
REQ-041 RESET asserted in SERVICE with IRQ[0] held high -> all outputs at reset values; no request after release until IRQ[0] falls and rises again.
REQ-042 VEC_BASE = 10'h3FE, N_CH = 4, channel 3 requested -> INT_VEC = 10'h001 (wrap).
